fabulous_alu_sched: RTL and testbench



---
 rtl/fabulous_alu_sched.sv | 123 ++++++++++++
 tb/tb_fabulous_alu_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fabulous_alu_sched.sv
// Word-serial add/sub scheduler: two requesters share one SLICE_W-bit carry-chain
// slice, and each operation is processed LSB-first, one slice per clock.
module fabulous_alu_sched #(
    parameter int SLICE_W = 8,
    parameter int WORDS   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ0_VALID,
    output logic                       REQ0_READY,
    input  logic [SLICE_W*WORDS-1:0]   REQ0_A,
    input  logic [SLICE_W*WORDS-1:0]   REQ0_B,
    input  logic                       REQ0_SUB,
    input  logic                       REQ1_VALID,
    output logic                       REQ1_READY,
    input  logic [SLICE_W*WORDS-1:0]   REQ1_A,
    input  logic [SLICE_W*WORDS-1:0]   REQ1_B,
    input  logic                       REQ1_SUB,
    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic                       RES_ID,
    output logic [SLICE_W*WORDS-1:0]   Y,
    output logic                       CO,
    output logic                       BUSY
);
    localparam int W  = SLICE_W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [W-1:0]        a_reg, b_reg, y_reg;
    logic                sub_reg, id_reg, last_reg, carry_reg, co_reg;
    logic [KW-1:0]       k_reg;

    logic                grant0, grant1, accept, accept_id, last_k;
    logic [SLICE_W-1:0]  a_words [WORDS];
    logic [SLICE_W-1:0]  b_words [WORDS];
    logic [SLICE_W-1:0]  a_slice, b_slice, b_eff;
    logic [SLICE_W:0]    slice_sum;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_words[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_words[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // Round robin: on a tie the requester that was not served last wins.
    assign grant0     = REQ0_VALID & (~REQ1_VALID | last_reg);
    assign grant1     = REQ1_VALID & (~REQ0_VALID | ~last_reg);
    assign REQ0_READY = (state_reg == IDLE) & ~RST & grant0;
    assign REQ1_READY = (state_reg == IDLE) & ~RST & grant1;
    assign accept     = REQ0_READY | REQ1_READY;
    assign accept_id  = REQ1_READY;

    assign a_slice   = a_words[k_reg];
    assign b_slice   = b_words[k_reg];
    assign b_eff     = sub_reg ? ~b_slice : b_slice;
    assign slice_sum = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_reg};
    assign last_k    = (k_reg == KW'(WORDS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_k)    state_next = DONE;
            DONE:    if (RES_READY) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            id_reg    <= 1'b0;
            last_reg  <= 1'b1;
            carry_reg <= 1'b0;
            k_reg     <= '0;
            y_reg     <= '0;
            co_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= accept_id ? REQ1_A : REQ0_A;
                        b_reg     <= accept_id ? REQ1_B : REQ0_B;
                        sub_reg   <= accept_id ? REQ1_SUB : REQ0_SUB;
                        // Subtraction is A + ~B + 1, so the chain starts with carry = SUB.
                        carry_reg <= accept_id ? REQ1_SUB : REQ0_SUB;
                        id_reg    <= accept_id;
                        last_reg  <= accept_id;
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    y_reg[k_reg*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
                    carry_reg <= slice_sum[SLICE_W];
                    if (last_k) begin
                        co_reg <= slice_sum[SLICE_W];
                        k_reg  <= '0;
                    end else begin
                        k_reg  <= k_reg + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign RES_VALID = (state_reg == DONE);
    assign BUSY      = (state_reg != IDLE);
    assign RES_ID    = id_reg;
    assign Y         = y_reg;
    assign CO        = co_reg;
endmodule

// File: tb/tb_fabulous_alu_sched.sv
// Directed bench for fabulous_alu_sched: a cycle-level arithmetic model checked every
// cycle, plus literal expectations for the key transactions.
module tb_fabulous_alu_sched;
    localparam int SLICE_W = 8;
    localparam int WORDS   = 4;
    localparam int W       = SLICE_W * WORDS;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic         REQ0_READY, REQ1_READY;
    logic [W-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic         REQ0_SUB = 1'b0, REQ1_SUB = 1'b0;
    logic         RES_VALID, RES_ID, CO, BUSY;
    logic         RES_READY = 1'b1;
    logic [W-1:0] Y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fabulous_alu_sched #(.SLICE_W(SLICE_W), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_SUB(REQ0_SUB),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_SUB(REQ1_SUB),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ID(RES_ID),
        .Y(Y), .CO(CO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 computing (m_cnt cycles left), 2 result held.
    int           m_phase = 0;
    int           m_cnt   = 0;
    logic         m_last  = 1'b1;
    logic         m_id    = 1'b0;
    logic         m_co    = 1'b0;
    logic [W-1:0] m_y     = '0;
    logic         p_co;
    logic [W-1:0] p_y;
    logic         g0, g1, e_r0, e_r1, op_id, op_sub;
    logic [W-1:0] op_a, op_b;
    int           hs_cyc[$];
    int           hs_id[$];

    always @(negedge CLK) begin
        if (RST) begin
            m_phase = 0; m_cnt = 0; m_last = 1'b1; m_id = 1'b0; m_co = 1'b0; m_y = '0;
        end
        g0   = REQ0_VALID && (!REQ1_VALID || m_last);
        g1   = REQ1_VALID && (!REQ0_VALID || !m_last);
        e_r0 = !RST && (m_phase == 0) && g0;
        e_r1 = !RST && (m_phase == 0) && g1;
        check("ready0", REQ0_READY, e_r0);
        check("ready1", REQ1_READY, e_r1);
        check("res_valid", RES_VALID, m_phase == 2);
        check("busy", BUSY, m_phase != 0);
        check("res_id", RES_ID, m_id);
        check("co", CO, m_co);
        if (m_phase != 1) check("y", Y, m_y);
        if (REQ0_VALID && REQ0_READY) begin hs_cyc.push_back(cyc); hs_id.push_back(0); end
        if (REQ1_VALID && REQ1_READY) begin hs_cyc.push_back(cyc); hs_id.push_back(1); end
        if (!RST) begin
            case (m_phase)
                0: if (e_r0 || e_r1) begin
                    op_id  = e_r1;
                    op_a   = op_id ? REQ1_A : REQ0_A;
                    op_b   = op_id ? REQ1_B : REQ0_B;
                    op_sub = op_id ? REQ1_SUB : REQ0_SUB;
                    if (op_sub) begin
                        p_y  = op_a - op_b;
                        p_co = (op_a >= op_b);
                    end else begin
                        {p_co, p_y} = {1'b0, op_a} + {1'b0, op_b};
                    end
                    m_last = op_id; m_id = op_id; m_phase = 1; m_cnt = WORDS;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_phase = 2; m_y = p_y; m_co = p_co; end
                end
                default: if (RES_READY) m_phase = 0;
            endcase
        end
    end

    task automatic wait_result(input string nm, input logic [W-1:0] ey, input logic eco, input logic eid);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (RES_VALID) begin n = i; break; end
        end
        check({nm, "_latency"}, n, 5);
        check({nm, "_y"}, Y, ey);
        check({nm, "_co"}, CO, eco);
        check({nm, "_id"}, RES_ID, eid);
    endtask

    task automatic wait_accept(input string nm, input logic req);
        logic hs;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge CLK);
            hs = req ? REQ1_READY : REQ0_READY;
        end
        check({nm, "_accept"}, hs, 1'b1);
    endtask

    task automatic do_op(input string nm, input logic req, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] ey, input logic eco);
        @(posedge CLK); #1;
        if (req) begin REQ1_VALID = 1'b1; REQ1_A = a; REQ1_B = b; REQ1_SUB = sub; end
        else     begin REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b; REQ0_SUB = sub; end
        wait_accept(nm, req);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        wait_result(nm, ey, eco, req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        @(negedge CLK);
        check("rst_ready0", REQ0_READY, 1'b0);
        check("rst_ready1", REQ1_READY, 1'b0);
        check("rst_y", Y, 0);
        check("rst_valid", RES_VALID, 1'b0);
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        do_op("add0", 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0);
        do_op("sub_pos", 1'b0, 32'd7, 32'd5, 1'b1, 32'd2, 1'b1);
        do_op("sub_neg", 1'b0, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0);
        do_op("add_wrap", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);

        // Both requesters held valid: alternating grants, six cycles apart.
        @(posedge CLK); #1;
        hs_cyc.delete(); hs_id.delete();
        REQ0_A = 32'h10; REQ0_B = 32'h20; REQ0_SUB = 1'b0;
        REQ1_A = 32'h1000; REQ1_B = 32'h3; REQ1_SUB = 1'b1;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        for (int i = 0; i < 60 && hs_id.size() < 4; i++) @(posedge CLK);
        #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        check("tie_count", hs_id.size(), 4);
        for (int i = 0; i < 4; i++)
            check("tie_id", (i < hs_id.size()) ? hs_id[i] : 99, i % 2);
        for (int i = 0; i < 3; i++)
            check("tie_gap", (i + 1 < hs_cyc.size()) ? hs_cyc[i+1] - hs_cyc[i] : 0, 6);
        repeat (8) @(posedge CLK);

        // Result stalled by the consumer while the other requester waits.
        #1;
        RES_READY = 1'b0;
        REQ0_A = 32'h1234_5678; REQ0_B = 32'h1111_1111; REQ0_SUB = 1'b0; REQ0_VALID = 1'b1;
        wait_accept("stall", 1'b0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        REQ1_A = 32'hAAAA_0000; REQ1_B = 32'h0000_5555; REQ1_SUB = 1'b0; REQ1_VALID = 1'b1;
        wait_result("stall", 32'h2345_6789, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_valid", RES_VALID, 1'b1);
            check("stall_y", Y, 32'h2345_6789);
            check("stall_ready1", REQ1_READY, 1'b0);
        end
        @(posedge CLK); #1;
        RES_READY = 1'b1;
        @(negedge CLK);
        check("stall_last_valid", RES_VALID, 1'b1);
        @(negedge CLK);
        check("resume_valid", RES_VALID, 1'b0);
        check("resume_ready1", REQ1_READY, 1'b1);
        @(posedge CLK); #1;
        REQ1_VALID = 1'b0;
        wait_result("resume", 32'hAAAA_5555, 1'b0, 1'b1);

        // Reset in the middle of a computation, at slice K=2.
        @(posedge CLK); #1;
        REQ0_A = 32'h0102_0304; REQ0_B = 32'h0101_0101; REQ0_SUB = 1'b0; REQ0_VALID = 1'b1;
        wait_accept("abort", 1'b0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_y", Y, 0);
        check("abort_co", CO, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_valid", RES_VALID, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (RES_VALID) n++;
        end
        check("abort_no_result", n, 0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        @(negedge CLK);
        check("post_rst_ready0", REQ0_READY, 1'b1);
        check("post_rst_ready1", REQ1_READY, 1'b0);
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        wait_result("post_rst", 32'h0203_0405, 1'b0, 1'b0);

        repeat (4) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
